bomb_manager: RTL and testbench

- Upstream feeder of the explosion stage; one instance per player.
- Accepts bomb-place requests and checks that the target map tile is free path.
- Writes the bomb tile into the shared map RAM and tracks up to MAX_BOMBS live fuses against the global timer.
- When a fuse expires, hands the bomb to the explosion stage via a ready/ack handshake carrying coordinate, blast length and player.

---
 rtl/bomb_manager.sv | 223 ++++++++++++++++++++++
 tb/tb_bomb_manager.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bomb_manager.sv
// bomb_manager: per-player bomb placement and fuse tracking.
//   Accepts place requests, checks the target tile is free path via the
//   shared map RAM, writes the bomb tile, keeps up to MAX_BOMBS live fuses
//   against the shared game timer and hands expired bombs to the explosion
//   stage over a ready/ack handshake.
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   place               one-cycle place request
//   player              player id (constant per instance)
//   player_pos          tile under player {row[3:0], col[3:0]}
//   length_cfg          current blast length level
//   timer               free-running game tick counter
//   Data_IN             map RAM read data for Address (combinational read)
//   ack                 explosion stage accept pulse
//   WE_O/Data_O/Address map RAM write port (registered)
//   ready               bomb waiting for the explosion stage
//   coordinate/length_out/player_out  detonating bomb description
//   bomb_count          number of live slots
//
// state | meaning
// IDLE  | waiting; fire expired bombs first, then service a pending place
// PL_RD | target tile address presented, checking Data_IN for path
// PL_WR | bomb tile written this cycle, slot filled
// FIRE  | ready high, holding bomb description until ack

module bomb_manager #(
    parameter int         MAX_BOMBS  = 2,
    parameter logic [9:0] FUSE_TICKS = 10'd24
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       place,
    input  logic       player,
    input  logic [7:0] player_pos,
    input  logic [1:0] length_cfg,
    input  logic [9:0] timer,
    input  logic [7:0] Data_IN,
    input  logic       ack,
    output logic       WE_O,
    output logic [7:0] Data_O,
    output logic [7:0] Address,
    output logic       ready,
    output logic [7:0] coordinate,
    output logic [1:0] length_out,
    output logic       player_out,
    output logic [2:0] bomb_count
);

    localparam int         IDXW      = (MAX_BOMBS > 1) ? $clog2(MAX_BOMBS) : 1;
    localparam logic [7:0] TILE_PATH = 8'h80;
    localparam logic [7:0] TILE_BOMB = 8'h60;

    typedef enum logic [1:0] {IDLE, PL_RD, PL_WR, FIRE} state_t;

    state_t state, state_nx;

    logic [MAX_BOMBS-1:0] slot_valid;
    logic [MAX_BOMBS-1:0] slot_expired;
    logic [7:0]           slot_coord    [MAX_BOMBS];
    logic [1:0]           slot_len      [MAX_BOMBS];
    logic [9:0]           slot_deadline [MAX_BOMBS];

    logic            place_pend;
    logic [7:0]      pos_q, pos_nx;
    logic [IDXW-1:0] fire_sel, fire_sel_nx;

    logic            fire_any, free_any;
    logic [IDXW-1:0] fire_idx, free_idx;
    logic [2:0]      count_c;

    logic       we_nx, ready_nx, pl_nx;
    logic [7:0] data_nx, addr_nx, coord_nx;
    logic [1:0] len_nx;
    logic       enter_rd, drop_full, do_fill, do_release;

    // Lowest-index search: iterate downward so the lowest match is kept.
    always_comb begin
        fire_any = 1'b0;
        fire_idx = '0;
        free_any = 1'b0;
        free_idx = '0;
        count_c  = 3'd0;
        for (int i = MAX_BOMBS - 1; i >= 0; i--) begin
            if (slot_expired[i]) begin
                fire_any = 1'b1;
                fire_idx = IDXW'(i);
            end
            if (!slot_valid[i]) begin
                free_any = 1'b1;
                free_idx = IDXW'(i);
            end
        end
        for (int i = 0; i < MAX_BOMBS; i++) begin
            count_c = count_c + 3'(slot_valid[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        we_nx       = 1'b0;
        data_nx     = Data_O;
        addr_nx     = Address;
        ready_nx    = ready;
        coord_nx    = coordinate;
        len_nx      = length_out;
        pl_nx       = player_out;
        pos_nx      = pos_q;
        fire_sel_nx = fire_sel;
        enter_rd    = 1'b0;
        drop_full   = 1'b0;
        do_fill     = 1'b0;
        do_release  = 1'b0;
        case (state)
            IDLE: begin
                if (fire_any) begin
                    fire_sel_nx = fire_idx;
                    coord_nx    = slot_coord[fire_idx];
                    len_nx      = slot_len[fire_idx];
                    pl_nx       = player;
                    ready_nx    = 1'b1;
                    state_nx    = FIRE;
                end else if (place_pend && free_any) begin
                    addr_nx  = player_pos;
                    pos_nx   = player_pos;
                    enter_rd = 1'b1;
                    state_nx = PL_RD;
                end else if (place_pend) begin
                    drop_full = 1'b1;
                end
            end
            PL_RD: begin
                if (Data_IN == TILE_PATH) begin
                    we_nx    = 1'b1;
                    data_nx  = TILE_BOMB;
                    state_nx = PL_WR;
                end else begin
                    state_nx = IDLE;
                end
            end
            PL_WR: begin
                do_fill  = free_any;
                state_nx = IDLE;
            end
            FIRE: begin
                if (ack) begin
                    do_release = 1'b1;
                    ready_nx   = 1'b0;
                    state_nx   = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            WE_O         <= 1'b0;
            Data_O       <= 8'h00;
            Address      <= 8'h00;
            ready        <= 1'b0;
            coordinate   <= 8'h00;
            length_out   <= 2'd0;
            player_out   <= 1'b0;
            bomb_count   <= 3'd0;
            place_pend   <= 1'b0;
            pos_q        <= 8'h00;
            fire_sel     <= '0;
            slot_valid   <= '0;
            slot_expired <= '0;
            for (int i = 0; i < MAX_BOMBS; i++) begin
                slot_coord[i]    <= 8'h00;
                slot_len[i]      <= 2'd0;
                slot_deadline[i] <= 10'd0;
            end
        end else begin
            WE_O       <= we_nx;
            Data_O     <= data_nx;
            Address    <= addr_nx;
            ready      <= ready_nx;
            coordinate <= coord_nx;
            length_out <= len_nx;
            player_out <= pl_nx;
            pos_q      <= pos_nx;
            fire_sel   <= fire_sel_nx;
            bomb_count <= count_c;

            // Pulses arriving while a request is pending merge into it.
            if (enter_rd || drop_full) begin
                place_pend <= 1'b0;
            end else if (place) begin
                place_pend <= 1'b1;
            end

            for (int i = 0; i < MAX_BOMBS; i++) begin
                // Sticky: expiry survives until the slot is handed off.
                if (slot_valid[i] && (timer == slot_deadline[i])) begin
                    slot_expired[i] <= 1'b1;
                end
                if (do_release && (fire_sel == IDXW'(i))) begin
                    slot_valid[i]   <= 1'b0;
                    slot_expired[i] <= 1'b0;
                end
                if (do_fill && (free_idx == IDXW'(i))) begin
                    slot_valid[i]    <= 1'b1;
                    slot_expired[i]  <= 1'b0;
                    slot_coord[i]    <= pos_q;
                    slot_len[i]      <= length_cfg;
                    slot_deadline[i] <= timer + FUSE_TICKS;
                end
            end
        end
    end

endmodule

// File: tb/tb_bomb_manager.sv
module tb_bomb_manager;

    localparam int         MAXB   = 2;
    localparam logic [9:0] FUSE   = 10'd24;
    localparam logic       PLAYER = 1'b1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       place = 1'b0;
    logic       player = PLAYER;
    logic [7:0] player_pos = 8'h00;
    logic [1:0] length_cfg = 2'd0;
    logic [9:0] timer = 10'd0;
    logic [7:0] Data_IN;
    logic       ack = 1'b0;
    logic       WE_O;
    logic [7:0] Data_O;
    logic [7:0] Address;
    logic       ready;
    logic [7:0] coordinate;
    logic [1:0] length_out;
    logic       player_out;
    logic [2:0] bomb_count;

    // Map RAM seen by the DUT; the bench plays the rest of the game world.
    logic [7:0] ram [256];
    assign Data_IN = ram[Address];

    bomb_manager #(.MAX_BOMBS(MAXB), .FUSE_TICKS(FUSE)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .place      (place),
        .player     (player),
        .player_pos (player_pos),
        .length_cfg (length_cfg),
        .timer      (timer),
        .Data_IN    (Data_IN),
        .ack        (ack),
        .WE_O       (WE_O),
        .Data_O     (Data_O),
        .Address    (Address),
        .ready      (ready),
        .coordinate (coordinate),
        .length_out (length_out),
        .player_out (player_out),
        .bomb_count (bomb_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] c;
        logic [1:0] l;
        logic       p;
    } fire_t;

    fire_t      fire_q [$];
    logic [7:0] write_q [$];
    int tests = 0;
    int fails = 0;
    int we_seen = 0;
    int fire_seen = 0;
    logic       ready_prev = 1'b0;
    logic [7:0] mon_addr;
    fire_t      mon_f;

    // Reference model: a list of live bombs per slot, lowest free slot taken.
    logic       m_valid [MAXB];
    logic [7:0] m_coord [MAXB];
    logic [1:0] m_len   [MAXB];
    logic [9:0] m_dl    [MAXB];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event observed, expected none", name);
    endtask

    function automatic int model_live();
        int n = 0;
        for (int s = 0; s < MAXB; s++) if (m_valid[s]) n++;
        return n;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT writes or raises ready.
    always @(negedge clk) begin
        if (WE_O) begin
            we_seen++;
            check("write_outside_fire", 32'(ready), 32'd0);
            if (write_q.size() == 0) begin
                fail_event("unexpected_write");
            end else begin
                mon_addr = write_q.pop_front();
                check("write_addr", 32'(Address), 32'(mon_addr));
                check("write_data", 32'(Data_O), 32'h60);
            end
        end
        if (ready && !ready_prev) begin
            fire_seen++;
            if (fire_q.size() == 0) begin
                fail_event("unexpected_ready");
            end else begin
                mon_f = fire_q.pop_front();
                check("fire_coord", 32'(coordinate), 32'(mon_f.c));
                check("fire_len", 32'(length_out), 32'(mon_f.l));
                check("fire_player", 32'(player_out), 32'(mon_f.p));
            end
        end
        ready_prev = ready;
    end

    task automatic wait_ready(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s: ready=0 after 40 cycles, expected ready=1", name);
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
    endtask

    // Queue the bomb in slot s for firing and drop it from the model.
    task automatic expect_fire(input int s);
        fire_t f;
        f.c = m_coord[s];
        f.l = m_len[s];
        f.p = PLAYER;
        fire_q.push_back(f);
        m_valid[s] = 1'b0;
    endtask

    task automatic tick();
        logic [7:0] gone [$];
        bit ok;
        int hold;
        @(posedge clk); #1;
        timer = timer + 10'd1;
        for (int s = 0; s < MAXB; s++) begin
            if (m_valid[s] && m_dl[s] == timer) begin
                gone.push_back(m_coord[s]);
                expect_fire(s);
            end
        end
        for (int k = 0; k < gone.size(); k++) begin
            wait_ready("fire_wait", ok);
            if (!ok) break;
            hold = $urandom_range(0, 3);
            repeat (hold) begin
                @(posedge clk); #1;
            end
            do_ack();
        end
        foreach (gone[k]) ram[gone[k]] = 8'h80;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic advance_to(input logic [9:0] t);
        for (int i = 0; i < 1100 && timer != t; i++) tick();
    endtask

    task automatic place_try(input logic [7:0] pos, input logic [7:0] tile, input logic [1:0] len);
        int  live;
        int  slot;
        bit  occupied;
        live = 0;
        slot = -1;
        occupied = 1'b0;
        for (int s = 0; s < MAXB; s++) begin
            if (m_valid[s]) begin
                live++;
                if (m_coord[s] == pos) occupied = 1'b1;
            end else if (slot < 0) begin
                slot = s;
            end
        end
        ram[pos]   = occupied ? 8'h60 : tile;
        length_cfg = len;
        player_pos = pos;
        if (!occupied && tile == 8'h80 && live < MAXB) begin
            m_valid[slot] = 1'b1;
            m_coord[slot] = pos;
            m_len[slot]   = len;
            m_dl[slot]    = timer + FUSE;
            write_q.push_back(pos);
        end
        place = 1'b1;
        @(posedge clk); #1;
        place = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic check_count(input string name);
        check(name, 32'(bomb_count), 32'(model_live()));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n, gap, we0, f0;
        bit stable;
        fire_t f;

        for (int a = 0; a < 256; a++) ram[a] = 8'h80;
        for (int s = 0; s < MAXB; s++) m_valid[s] = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_we", 32'(WE_O), 32'd0);
        check("rst_data", 32'(Data_O), 32'h00);
        check("rst_addr", 32'(Address), 32'h00);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_coord", 32'(coordinate), 32'h00);
        check("rst_len", 32'(length_out), 32'd0);
        check("rst_player", 32'(player_out), 32'd0);
        check("rst_count", 32'(bomb_count), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Place on path with latency measurement
        timer = 10'd100;
        ram[8'h23] = 8'h80;
        player_pos = 8'h23;
        length_cfg = 2'd2;
        m_valid[0] = 1'b1; m_coord[0] = 8'h23; m_len[0] = 2'd2; m_dl[0] = 10'd124;
        write_q.push_back(8'h23);
        place = 1'b1;
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) place = 1'b0;
            if (WE_O && n == 0) n = i;
        end
        check("place_latency", 32'(n), 32'd3);
        check("count_after_place", 32'(bomb_count), 32'd1);
        advance_to(10'd124);
        check("ready_after_ack", 32'(ready), 32'd0);
        check("count_after_fire", 32'(bomb_count), 32'd0);

        // Blocked tiles
        we0 = we_seen;
        place_try(8'h45, 8'h00, 2'd1);
        place_try(8'h45, 8'h10, 2'd1);
        place_try(8'h45, 8'h60, 2'd1);
        ram[8'h45] = 8'h80;
        check("blocked_no_write", 32'(we_seen - we0), 32'd0);
        check("blocked_count", 32'(bomb_count), 32'd0);

        // Capacity, then simultaneous expiry of both slots
        timer = 10'd200;
        we0 = we_seen;
        place_try(8'h11, 8'h80, 2'd0);
        place_try(8'h13, 8'h80, 2'd1);
        place_try(8'h15, 8'h80, 2'd2);
        check("capacity_writes", 32'(we_seen - we0), 32'd2);
        check("capacity_count", 32'(bomb_count), 32'd2);
        advance_to(10'd224);
        check_count("capacity_drain");

        // Deadline wraps past 1023; both expire at timer 10
        timer = 10'd1010;
        place_try(8'h31, 8'h80, 2'd3);
        place_try(8'h32, 8'h80, 2'd1);
        advance_to(10'd9);
        @(posedge clk); #1;
        timer = 10'd10;
        expect_fire(0);
        expect_fire(1);
        wait_ready("wrap_fire0", ok);
        repeat (2) @(posedge clk);
        #1;
        do_ack();
        check("ready_drop_on_ack", 32'(ready), 32'd0);
        gap = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                gap = i;
                break;
            end
        end
        check("refire_gap", 32'(gap), 32'd1);
        do_ack();
        ram[8'h31] = 8'h80;
        ram[8'h32] = 8'h80;
        repeat (2) @(posedge clk);
        #1;
        check_count("wrap_drain");

        // Ack withheld for 50 cycles; place during FIRE serviced afterwards
        timer = 10'd300;
        place_try(8'h52, 8'h80, 2'd1);
        length_cfg = 2'd3;
        advance_to(10'd323);
        @(posedge clk); #1;
        timer = 10'd324;
        expect_fire(0);
        wait_ready("hold_fire", ok);
        we0 = we_seen;
        stable = 1'b1;
        ram[8'h53] = 8'h80;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) begin
                player_pos = 8'h53;
                place = 1'b1;
            end
            if (i == 11) place = 1'b0;
            @(posedge clk); #1;
            if (!ready || coordinate != 8'h52 || length_out != 2'd1 || player_out != PLAYER)
                stable = 1'b0;
        end
        check("fire_hold_stable", 32'(stable), 32'd1);
        check("no_write_during_fire", 32'(we_seen - we0), 32'd0);
        m_valid[0] = 1'b1; m_coord[0] = 8'h53; m_len[0] = 2'd3; m_dl[0] = 10'd348;
        write_q.push_back(8'h53);
        do_ack();
        ram[8'h52] = 8'h80;
        repeat (6) @(posedge clk);
        #1;
        check("deferred_place_write", 32'(we_seen - we0), 32'd1);
        check("deferred_place_count", 32'(bomb_count), 32'd1);
        advance_to(10'd348);
        check_count("deferred_drain");

        // Reset while ready is high
        timer = 10'd400;
        place_try(8'h61, 8'h80, 2'd2);
        advance_to(10'd423);
        @(posedge clk); #1;
        timer = 10'd424;
        expect_fire(0);
        wait_ready("reset_fire", ok);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_ready", 32'(ready), 32'd0);
        check("async_rst_count", 32'(bomb_count), 32'd0);
        check("async_rst_coord", 32'(coordinate), 32'h00);
        @(posedge clk); #1;
        reset_n = 1'b1;
        ram[8'h61] = 8'h80;
        f0 = fire_seen;
        advance_to(10'd454);
        check("no_fire_after_reset", 32'(fire_seen - f0), 32'd0);
        check_count("count_after_reset");

        // Randomized placements and time advances
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) != 2) begin
                logic [7:0] tile;
                case ($urandom_range(0, 5))
                    3: tile = 8'h00;
                    4: tile = 8'h10;
                    5: tile = 8'h60;
                    default: tile = 8'h80;
                endcase
                place_try(8'($urandom_range(0, 255)), tile, 2'($urandom_range(0, 3)));
            end else begin
                n = $urandom_range(1, 10);
                repeat (n) tick();
            end
            check_count("random_count");
        end
        repeat (26) tick();
        check_count("final_count");
        check("write_q_empty", 32'(write_q.size()), 32'd0);
        check("fire_q_empty", 32'(fire_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
